// File: rtl/tx_stream_arbiter.sv
// Round-robin frame arbiter: grants one source per frame and forwards its words to a single transmitter.
// Optional frame header word enabled by defining TX_STREAM_ARBITER_HEADER_EN.
module tx_stream_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int SOURCES    = 4,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SOURCES*DATA_WIDTH-1:0] src_data,
    input  logic [SOURCES-1:0]            src_rdy,
    input  logic [SOURCES-1:0]            src_eof,
    output logic [SOURCES-1:0]            src_ack,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_rdy,
    input  logic                          tx_ack,
    output logic                          busy,
    output logic [IDX_WIDTH-1:0]          grant_idx,
    output logic [15:0]                   frame_words
);

    typedef enum logic [1:0] {IDLE, GRANT, HEADER, FORWARD} state_t;

    state_t                state_q, state_d;
    logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0]  grant_q, grant_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           frame_words_q, frame_words_d;

    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_rdy;
    logic                  sel_eof;
    logic                  req_found;
    logic [IDX_WIDTH-1:0]  req_idx;
    logic [IDX_WIDTH-1:0]  ptr_next;
    logic [15:0]           count_inc;

    always_comb begin
        sel_data = '0;
        sel_rdy  = 1'b0;
        sel_eof  = 1'b0;
        for (int i = 0; i < SOURCES; i++) begin
            if (grant_q == IDX_WIDTH'(i)) begin
                sel_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_rdy  = src_rdy[i];
                sel_eof  = src_eof[i];
            end
        end
    end

    // ptr_q is always below SOURCES, so one conditional subtract wraps the scan position.
    always_comb begin
        int pos;
        req_found = 1'b0;
        req_idx   = ptr_q;
        for (int k = 0; k < SOURCES; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= SOURCES) pos = pos - SOURCES;
            for (int i = 0; i < SOURCES; i++) begin
                if (!req_found && i == pos && src_rdy[i]) begin
                    req_found = 1'b1;
                    req_idx   = IDX_WIDTH'(i);
                end
            end
        end
    end

    assign ptr_next  = (int'(grant_q) == SOURCES - 1) ? '0 : grant_q + IDX_WIDTH'(1);
    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

`ifdef TX_STREAM_ARBITER_HEADER_EN
    logic [DATA_WIDTH-1:0] header_word;

    always_comb begin
        header_word                      = '0;
        header_word[DATA_WIDTH-1 -: 4]   = 4'hA;
        header_word[IDX_WIDTH-1:0]       = grant_q;
    end
`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        count_d       = count_q;
        frame_words_d = frame_words_q;
        tx_rdy        = 1'b0;
        tx_data       = '0;
        src_ack       = '0;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    grant_d = req_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
`ifdef TX_STREAM_ARBITER_HEADER_EN
                state_d = HEADER;
`else
                state_d = FORWARD;
`endif
            end
            HEADER: begin
`ifdef TX_STREAM_ARBITER_HEADER_EN
                tx_rdy  = 1'b1;
                tx_data = header_word;
                if (tx_ack) state_d = FORWARD;
`else
                state_d = FORWARD;
`endif
            end
            FORWARD: begin
                tx_data = sel_data;
                tx_rdy  = sel_rdy;
                for (int i = 0; i < SOURCES; i++) begin
                    if (grant_q == IDX_WIDTH'(i)) src_ack[i] = sel_rdy & tx_ack;
                end
                if (sel_rdy && tx_ack) begin
                    count_d = count_inc;
                    if (sel_eof) begin
                        frame_words_d = count_inc;
                        count_d       = '0;
                        ptr_d         = ptr_next;
                        state_d       = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            count_q       <= '0;
            frame_words_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            count_q       <= count_d;
            frame_words_q <= frame_words_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign grant_idx   = grant_q;
    assign frame_words = frame_words_q;

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Scoreboard bench for tx_stream_arbiter: source word FIFOs feed the DUT, expected tx words are queued
// in arbitration order and popped as the transmitter side accepts them.
module tb_tx_stream_arbiter;

    localparam int DW = 8;
    localparam int NS = 4;
    localparam int IW = 2;
`ifdef TX_STREAM_ARBITER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    typedef struct packed {
        logic       hdr;
        logic [1:0] src;
        logic [7:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*DW-1:0]  src_data;
    logic [NS-1:0]     src_rdy;
    logic [NS-1:0]     src_eof;
    logic [NS-1:0]     src_ack;
    logic [DW-1:0]     tx_data;
    logic              tx_rdy;
    logic              tx_ack;
    logic              busy;
    logic [IW-1:0]     grant_idx;
    logic [15:0]       frame_words;

    int                vecCount  = 0;
    int                missCount = 0;
    int                xferCount = 0;
    exp_t              expQ[$];
    logic [8:0]        srcMem[NS][32];
    int                wrPtr[NS] = '{default: 0};
    int                rdPtr[NS] = '{default: 0};
    logic [NS-1:0]     hold      = '0;
    logic [NS-1:0]     ackSnap   = '0;

    always #5 clk = ~clk;

    tx_stream_arbiter #(.DATA_WIDTH(DW), .SOURCES(NS), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .src_data(src_data), .src_rdy(src_rdy), .src_eof(src_eof), .src_ack(src_ack),
        .tx_data(tx_data), .tx_rdy(tx_rdy), .tx_ack(tx_ack),
        .busy(busy), .grant_idx(grant_idx), .frame_words(frame_words)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic loadWord(input int s, input logic [7:0] d, input logic eof);
        srcMem[s][wrPtr[s] % 32] = {eof, d};
        wrPtr[s]++;
    endtask

    // Queues one expected forwarded word; the first word of a frame is preceded by the header when enabled.
    task automatic expectWord(input int s, input logic [7:0] d, input logic first);
        exp_t e;
        if (first && HDR != 0) begin
            e.hdr  = 1'b1;
            e.src  = 2'(s);
            e.data = 8'hA0 | 8'(s);
            expQ.push_back(e);
        end
        e.hdr  = 1'b0;
        e.src  = 2'(s);
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic waitXfers(input int n);
        int target;
        int cycles;
        target = xferCount + n;
        cycles = 0;
        while (xferCount < target && cycles < 300) begin
            tick(1);
            cycles++;
        end
        if (xferCount < target) checkOutput("xfer_timeout", 32'(xferCount), 32'(target));
    endtask

    // Source model: pops words the DUT acknowledged, then presents the next head-of-queue word.
    initial begin
        forever begin
            for (int i = 0; i < NS; i++) begin
                src_rdy[i]             = (rdPtr[i] != wrPtr[i]) && !hold[i];
                src_eof[i]             = srcMem[i][rdPtr[i] % 32][8];
                src_data[i*DW +: DW]   = srcMem[i][rdPtr[i] % 32][7:0];
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) if (ackSnap[i]) rdPtr[i]++;
            #1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        ackSnap = '0;
        if (!rst) begin
            if (tx_rdy && tx_ack) begin
                if (expQ.size() == 0) begin
                    checkOutput("tx_unexpected", 32'(expQ.size()), 32'd1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("tx_data", 32'(tx_data), 32'(e.data));
                    checkOutput("grant_idx", 32'(grant_idx), 32'(e.src));
                    checkOutput("src_ack", 32'(src_ack), e.hdr ? 32'd0 : 32'(4'b0001 << e.src));
                end
                ackSnap = src_ack;
                xferCount++;
            end else if (src_ack != '0) begin
                checkOutput("ack_no_xfer", 32'(src_ack), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus();
        rst    = 1'b1;
        tx_ack = 1'b1;
        tick(2);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_tx_rdy", 32'(tx_rdy), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_src_ack", 32'(src_ack), 32'd0);
        checkOutput("rst_grant", 32'(grant_idx), 32'd0);
        checkOutput("rst_frame_words", 32'(frame_words), 32'd0);
        rst = 1'b0;
        tick(1);

        // Three-word frame from source 2, with the two-cycle grant bubble
        loadWord(2, 8'h11, 1'b0); loadWord(2, 8'h22, 1'b0); loadWord(2, 8'h33, 1'b1);
        expectWord(2, 8'h11, 1'b1); expectWord(2, 8'h22, 1'b0); expectWord(2, 8'h33, 1'b0);
        tick(1);
        checkOutput("lat_grant_busy", 32'(busy), 32'd1);
        checkOutput("lat_grant_tx_rdy", 32'(tx_rdy), 32'd0);
        tick(1);
        checkOutput("lat_first_tx_rdy", 32'(tx_rdy), 32'd1);
        waitXfers(3 + HDR);
        checkOutput("fw_three", 32'(frame_words), 32'd3);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Pointer now 3: source 3 wins over source 0
        loadWord(0, 8'h40, 1'b1); loadWord(3, 8'h43, 1'b1);
        expectWord(3, 8'h43, 1'b1); expectWord(0, 8'h40, 1'b1);
        waitXfers(2 + 2*HDR);
        checkOutput("fw_single", 32'(frame_words), 32'd1);

        // All sources request right after reset
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        loadWord(0, 8'hA0, 1'b1); loadWord(0, 8'hA4, 1'b1);
        loadWord(1, 8'hA1, 1'b1); loadWord(2, 8'hA2, 1'b1); loadWord(3, 8'hA3, 1'b1);
        expectWord(0, 8'hA0, 1'b1); expectWord(1, 8'hA1, 1'b1); expectWord(2, 8'hA2, 1'b1);
        expectWord(3, 8'hA3, 1'b1); expectWord(0, 8'hA4, 1'b1);
        waitXfers(5 + 5*HDR);

        // Source 1 stalls mid-frame; source 0 must wait for its eof
        loadWord(1, 8'h51, 1'b0); loadWord(1, 8'h52, 1'b0); loadWord(1, 8'h53, 1'b1);
        expectWord(1, 8'h51, 1'b1); expectWord(1, 8'h52, 1'b0); expectWord(1, 8'h53, 1'b0);
        waitXfers(1 + HDR);
        hold[1] = 1'b1;
        loadWord(0, 8'h60, 1'b1);
        expectWord(0, 8'h60, 1'b1);
        repeat (5) begin
            tick(1);
            checkOutput("stall_busy", 32'(busy), 32'd1);
            checkOutput("stall_grant", 32'(grant_idx), 32'd1);
            checkOutput("stall_tx_rdy", 32'(tx_rdy), 32'd0);
        end
        hold[1] = 1'b0;
        waitXfers(3 + HDR);

        // Transmitter back-pressure
        tx_ack = 1'b0;
        loadWord(2, 8'h77, 1'b1);
        expectWord(2, 8'h77, 1'b1);
        tick(2);
        repeat (10) begin
            checkOutput("bp_tx_rdy", 32'(tx_rdy), 32'd1);
            checkOutput("bp_tx_data", 32'(tx_data), (HDR != 0) ? 32'hA2 : 32'h77);
            tick(1);
        end
        tx_ack = 1'b1;
        waitXfers(1 + HDR);

        // Reset during word 2 of a four-word frame from source 1
        loadWord(1, 8'h81, 1'b0); loadWord(1, 8'h82, 1'b0);
        loadWord(1, 8'h83, 1'b0); loadWord(1, 8'h84, 1'b1);
        expectWord(1, 8'h81, 1'b1);
        waitXfers(1 + HDR);
        rst = 1'b1;
        #2;
        checkOutput("abort_tx_rdy", 32'(tx_rdy), 32'd0);
        checkOutput("abort_tx_data", 32'(tx_data), 32'd0);
        checkOutput("abort_src_ack", 32'(src_ack), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_grant", 32'(grant_idx), 32'd0);
        checkOutput("abort_frame_words", 32'(frame_words), 32'd0);
        wrPtr[1] = rdPtr[1];
        tick(1);
        rst = 1'b0;
        loadWord(3, 8'h93, 1'b1); loadWord(0, 8'h90, 1'b1);
        expectWord(0, 8'h90, 1'b1); expectWord(3, 8'h93, 1'b1);
        waitXfers(2 + 2*HDR);

`ifdef TX_STREAM_ARBITER_HEADER_EN
        loadWord(3, 8'h55, 1'b1);
        expectWord(3, 8'h55, 1'b1);
        waitXfers(2);
        checkOutput("hdr_frame_words", 32'(frame_words), 32'd1);
`endif
    endtask

    initial begin
        applyStimulus();
        tick(2);
        checkOutput("exp_drained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/tx_stream_arbiter.md
TX_STREAM_ARBITER -- requirements
Module: tx_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width of all streams.
REQ-002 SHALL have parameter SOURCES, default 4, number of frame sources (1..16).
REQ-003 SHALL have parameter IDX_WIDTH, default 2, source index width; must be >= clog2(SOURCES), minimum 1.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  async active-high reset.
REQ-005 src_data  input  SOURCES*DATA_WIDTH  source i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 src_rdy  input  SOURCES  source i word valid.
REQ-007 src_eof  input  SOURCES  source i word is the last word of its frame.
REQ-008 src_ack  output  SOURCES  one-cycle pulse: source i word consumed.
REQ-009 tx_data  output  DATA_WIDTH  word to transmitter.
REQ-010 tx_rdy  output  1  tx_data valid.
REQ-011 tx_ack  input  1  transmitter accepts tx_data this cycle.
REQ-012 busy  output  1  a frame is granted.
REQ-013 grant_idx  output  IDX_WIDTH  index of granted source; holds last grant when idle.
REQ-014 frame_words  output  16  word count of the last completed frame, saturating at 16'hFFFF.

Function
REQ-015 Transfer on tx SHALL occur only on a cycle with tx_rdy=1 and tx_ack=1; tx_ack with tx_rdy=0 SHALL be ignored.
REQ-016 FSM states SHALL be IDLE, GRANT, HEADER, FORWARD.
REQ-017 IDLE: if any src_rdy=1, select first requester scanning from ptr upward modulo SOURCES; register grant_idx; go to GRANT; otherwise stay.
REQ-018 GRANT: busy=1; go to HEADER if header enabled, else FORWARD (grant-to-first-word latency 2 cycles after src_rdy seen in IDLE).
REQ-019 FORWARD: tx_data=src_data[grant], tx_rdy=src_rdy[grant], src_ack[grant]=tx_ack AND src_rdy[grant], combinational; all other src_ack bits 0.
REQ-020 FORWARD: each transfer increments internal word counter (saturating); transfer with src_eof[grant]=1 loads frame_words, sets ptr=grant+1 modulo SOURCES, returns to IDLE.
REQ-021 Granted source dropping src_rdy mid-frame SHALL hold the grant indefinitely; no other source may interleave.
REQ-022 src_eof and src_rdy of non-granted sources SHALL be ignored; their src_ack SHALL stay 0.
REQ-023 Single-word frame (eof on first word) SHALL give frame_words=1.
REQ-024 With SOURCES=1 arbitration SHALL degenerate to a pass-through with the GRANT bubble.
REQ-025 Outside FORWARD/HEADER, tx_rdy=0 and tx_data=0.

Reset
REQ-026 On rst: state IDLE, ptr=0, grant_idx=0, busy=0, tx_rdy=0, tx_data=0, src_ack=0, frame_words=0, word counter=0.
REQ-027 Reset mid-frame SHALL abort the frame immediately with no further src_ack; no frame_words update.

Configuration
REQ-028 Macro TX_STREAM_ARBITER_HEADER_EN defined: HEADER state drives tx_rdy=1, tx_data={4'hA, zeros, grant_idx} (idx in LSBs), waits for tx_ack, then FORWARD; header not counted in frame_words; requires DATA_WIDTH >= 4+IDX_WIDTH.
REQ-029 Macro undefined: HEADER state unreachable, GRANT goes directly to FORWARD.

Verification
REQ-030 Src2 only, 3-word frame 11,22,33 with eof on 33, tx_ack held 1 -> tx sees 11,22,33; src_ack[2] three pulses; frame_words=3; ptr=3.
REQ-031 All 4 sources request simultaneously after reset, 1-word frames -> grant order 0,1,2,3 then 0; no interleaving.
REQ-032 Src1 frame, src_rdy[1] low 5 cycles mid-frame while src0 requests -> src0 not granted until src1 eof.
REQ-033 tx_ack=0 for 10 cycles with word pending -> tx_data/tx_rdy stable, no src_ack.
REQ-034 rst asserted during word 2 of a 4-word frame -> all outputs 0 same cycle, next grant from src0.
REQ-035 With TX_STREAM_ARBITER_HEADER_EN, src3 frame 55 (eof) -> tx sees 8'hA3 then 55; frame_words=1.
